// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, the
// in-flight access record and the MEM/WB entry layout.
package mem_stage_pkg;

  localparam int DATA_W             = 32;
  localparam int WB_SEL_W           = 2;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Everything captured when a memory op is accepted, so the stage can run
  // the dmem handshake while upstream is frozen.
  typedef struct packed {
    logic                is_store;
    logic                is_load;
    logic                rf_we;
    logic [WB_SEL_W-1:0] sel2;
    logic [WB_SEL_W-1:0] sel4;
    logic [DATA_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   add_pc;
  } acc_t;

  typedef struct packed {
    logic                valid;
    logic                rf_we;
    logic [WB_SEL_W-1:0] sel2;
    logic [WB_SEL_W-1:0] sel4;
    logic [DATA_W-1:0]   mem_data;
    logic [DATA_W-1:0]   alu;
    logic [DATA_W-1:0]   add_pc;
  } wb_entry_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble load clears the whole entry so that a
// squashed slot never carries stale write-back data.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load_bubble_i,
  input  wb_entry_t entry_i,
  output wb_entry_t entry_o
);

  wb_entry_t entry_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
    end else if (load_bubble_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_i;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: dmem request/ack handshake, stall/branch-redirect generation and
// the MEM/WB register. Optional access timeout enabled by macro MEM_TIMEOUT_EN.
//   state     | meaning
//   ST_IDLE   | no access in flight; ALU/branch ops pass straight to MEM/WB
//   ST_ACCESS | dmem request held stable until ack (or timeout)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic                mem_re_in,
  input  logic                mem_we_in,
  input  logic                reg_file_write_in,
  input  logic                branch_in,
  input  logic [WB_SEL_W-1:0] select_mux_2_in,
  input  logic [WB_SEL_W-1:0] select_mux_4_in,
  input  logic [DATA_W-1:0]   reg_b_in,
  input  logic [DATA_W-1:0]   alu_in,
  input  logic [DATA_W-1:0]   add_pc_in,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DATA_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                stall_out,
  output logic                pc_src_out,
  output logic [DATA_W-1:0]   branch_target_out,
  output logic                valid_out,
  output logic                reg_file_write_out,
  output logic [WB_SEL_W-1:0] select_mux_2_out,
  output logic [WB_SEL_W-1:0] select_mux_4_out,
  output logic [DATA_W-1:0]   mem_data_out,
  output logic [DATA_W-1:0]   alu_out,
  output logic [DATA_W-1:0]   add_pc_out,
  output logic                err_out
);

  state_e    state_q, state_d;
  acc_t      acc_q, acc_d;
  wb_entry_t wb_d, wb_q;
  logic      wb_bubble;
  logic      mem_op;
  logic      accept;
  logic      timeout_hit;

  assign mem_op = mem_re_in | mem_we_in;
  assign accept = (state_q == ST_IDLE) & valid_in & mem_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: if (dmem_ack || timeout_hit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    dmem_addr         = '0;
    dmem_wdata        = '0;
    stall_out         = accept | ((state_q == ST_ACCESS) & ~dmem_ack);
    pc_src_out        = (state_q == ST_IDLE) & valid_in & branch_in & ~mem_op;
    branch_target_out = pc_src_out ? add_pc_in : '0;
    if (state_q == ST_ACCESS) begin
      dmem_req   = 1'b1;
      dmem_we    = acc_q.is_store;
      dmem_addr  = acc_q.addr;
      dmem_wdata = acc_q.wdata;
    end
  end

  // A simultaneous load+store request resolves to a store.
  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d.is_store = mem_we_in;
      acc_d.is_load  = mem_re_in & ~mem_we_in;
      acc_d.rf_we    = reg_file_write_in;
      acc_d.sel2     = select_mux_2_in;
      acc_d.sel4     = select_mux_4_in;
      acc_d.addr     = alu_in;
      acc_d.wdata    = reg_b_in;
      acc_d.add_pc   = add_pc_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    wb_d       = '0;
    wb_bubble  = 1'b1;
    wb_d.valid = 1'b1;
    if (state_q == ST_IDLE) begin
      wb_bubble     = ~valid_in | mem_op;
      wb_d.rf_we    = reg_file_write_in;
      wb_d.sel2     = select_mux_2_in;
      wb_d.sel4     = select_mux_4_in;
      wb_d.alu      = alu_in;
      wb_d.add_pc   = add_pc_in;
    end else begin
      wb_bubble     = ~dmem_ack;
      wb_d.rf_we    = acc_q.rf_we;
      wb_d.sel2     = acc_q.sel2;
      wb_d.sel4     = acc_q.sel4;
      wb_d.alu      = acc_q.addr;
      wb_d.add_pc   = acc_q.add_pc;
      wb_d.mem_data = acc_q.is_load ? dmem_rdata : '0;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk           (clk),
    .reset         (reset),
    .load_bubble_i (wb_bubble),
    .entry_i       (wb_d),
    .entry_o       (wb_q)
  );

  assign valid_out          = wb_q.valid;
  assign reg_file_write_out = wb_q.rf_we;
  assign select_mux_2_out   = wb_q.sel2;
  assign select_mux_4_out   = wb_q.sel4;
  assign mem_data_out       = wb_q.mem_data;
  assign alu_out            = wb_q.alu;
  assign add_pc_out         = wb_q.add_pc;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The counter only survives while the FSM stays in ACCESS.
  always_comb begin
    timeout_hit = (state_q == ST_ACCESS) && !dmem_ack &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d       = ((state_q == ST_ACCESS) && (state_d == ST_ACCESS)) ?
                  cnt_q + 1'b1 : '0;
    err_d       = err_q | timeout_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign err_out            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized instruction stream plus directed
// cases, with a decoupled MEM/WB monitor; timeout cases when MEM_TIMEOUT_EN.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 16;
`endif

  logic        clk, reset;
  logic        valid_in, mem_re_in, mem_we_in, reg_file_write_in, branch_in;
  logic [1:0]  select_mux_2_in, select_mux_4_in;
  logic [31:0] reg_b_in, alu_in, add_pc_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_out, pc_src_out;
  logic [31:0] branch_target_out;
  logic        valid_out, reg_file_write_out, err_out;
  logic [1:0]  select_mux_2_out, select_mux_4_out;
  logic [31:0] mem_data_out, alu_out, add_pc_out;

  mem_stage #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_re_in(mem_re_in),
    .mem_we_in(mem_we_in), .reg_file_write_in(reg_file_write_in),
    .branch_in(branch_in), .select_mux_2_in(select_mux_2_in),
    .select_mux_4_in(select_mux_4_in), .reg_b_in(reg_b_in), .alu_in(alu_in),
    .add_pc_in(add_pc_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_out(stall_out), .pc_src_out(pc_src_out),
    .branch_target_out(branch_target_out), .valid_out(valid_out),
    .reg_file_write_out(reg_file_write_out),
    .select_mux_2_out(select_mux_2_out), .select_mux_4_out(select_mux_4_out),
    .mem_data_out(mem_data_out), .alu_out(alu_out), .add_pc_out(add_pc_out),
    .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rfw;
    logic [1:0]  s2, s4;
    logic [31:0] md, alu, pc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  bit   mon_en = 0;
  bit   exp_vld = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge the MEM/WB slot must match the scoreboard head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("valid_out", valid_out, exp_vld);
        if (!valid_out) chk("bubble_rfw", reg_file_write_out, 0);
        else if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_entry: got valid_out=1 expected empty scoreboard");
        end else begin
          mon_e = q.pop_front();
          chk("rfw_out", reg_file_write_out, mon_e.rfw);
          chk("sel2_out", select_mux_2_out, mon_e.s2);
          chk("sel4_out", select_mux_4_out, mon_e.s4);
          chk("mem_data_out", mem_data_out, mon_e.md);
          chk("alu_out", alu_out, mon_e.alu);
          chk("add_pc_out", add_pc_out, mon_e.pc);
        end
      end
    end
  end

  task automatic junk_inputs();
    valid_in = 1'($urandom); mem_re_in = 1'($urandom); mem_we_in = 1'($urandom);
    reg_file_write_in = 1'($urandom); branch_in = 1'($urandom);
    select_mux_2_in = 2'($urandom); select_mux_4_in = 2'($urandom);
    reg_b_in = $urandom; alu_in = $urandom; add_pc_in = $urandom;
  endtask

  // One instruction: issue, then (for a memory op) play the memory side with
  // `delay` wait cycles before the ack.
  task automatic do_instr(input logic v, re, we, rfw, br, input logic [1:0] s2, s4,
                          input logic [31:0] rb, alu, pc, input int delay,
                          input logic [31:0] rdata);
    bit   memop = v && (re || we);
    bit   redir = v && br && !memop;
    exp_t e;
    e.rfw = rfw; e.s2 = s2; e.s4 = s4; e.alu = alu; e.pc = pc; e.md = 0;
    @(negedge clk);
    valid_in = v; mem_re_in = re; mem_we_in = we; reg_file_write_in = rfw;
    branch_in = br; select_mux_2_in = s2; select_mux_4_in = s4;
    reg_b_in = rb; alu_in = alu; add_pc_in = pc;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    #1;
    chk("stall_idle", stall_out, memop);
    chk("pc_src", pc_src_out, redir);
    chk("branch_target", branch_target_out, redir ? pc : 32'h0);
    chk("dmem_req_idle", dmem_req, 0);
    chk("dmem_addr_idle", dmem_addr, 0);
    if (!memop) begin
      exp_vld = v;
      if (v) q.push_back(e);
    end else begin
      exp_vld = 0;
      for (int k = 0; k <= delay; k++) begin
        @(negedge clk);
        junk_inputs();
        dmem_ack   = (k == delay);
        dmem_rdata = (k == delay) ? rdata : $urandom;
        #1;
        chk("dmem_req", dmem_req, 1);
        chk("dmem_we", dmem_we, we);
        chk("dmem_addr", dmem_addr, alu);
        chk("dmem_wdata", dmem_wdata, rb);
        chk("stall_access", stall_out, k != delay);
        chk("pc_src_access", pc_src_out, 0);
        exp_vld = (k == delay);
        if (k == delay) begin
          e.md = (re && !we) ? rdata : 32'h0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_rfw_out"}, reg_file_write_out, 0);
    chk({tag, "_alu_out"}, alu_out, 0);
    chk({tag, "_mem_data_out"}, mem_data_out, 0);
    chk({tag, "_add_pc_out"}, add_pc_out, 0);
    chk({tag, "_dmem_req"}, dmem_req, 0);
    chk({tag, "_dmem_addr"}, dmem_addr, 0);
    chk({tag, "_err_out"}, err_out, 0);
  endtask

  task automatic idle_inputs();
    valid_in = 0; mem_re_in = 0; mem_we_in = 0; reg_file_write_in = 0;
    branch_in = 0; select_mux_2_in = 0; select_mux_4_in = 0;
    reg_b_in = 0; alu_in = 0; add_pc_in = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    chk("reset_stall", stall_out, 0);
    @(negedge clk);
    reset = 1;
    mon_en = 1;

    // Directed: ALU op, 3-wait load, 0-wait store, branch redirect, no-redirect.
    do_instr(1, 0, 0, 1, 0, 2'd1, 2'd2, 32'h0, 32'h55, 32'h4, 0, 32'h0);
    do_instr(1, 1, 0, 1, 0, 2'd0, 2'd1, 32'h7, 32'h100, 32'h8, 3, 32'hDEAD_BEEF);
    do_instr(1, 0, 1, 0, 0, 2'd3, 2'd0, 32'h1234, 32'h40, 32'hC, 0, 32'hFFFF_FFFF);
    do_instr(1, 0, 0, 0, 1, 2'd2, 2'd3, 32'h0, 32'h9, 32'h80, 0, 32'h0);
    do_instr(0, 0, 0, 1, 1, 2'd2, 2'd3, 32'h0, 32'h9, 32'h80, 0, 32'h0);
    do_instr(1, 1, 1, 1, 0, 2'd1, 2'd1, 32'hAB, 32'h200, 32'h10, 1, 32'h5555_AAAA);

    for (int n = 0; n < 250; n++) begin
      logic v, re, we;
      v  = ($urandom_range(0, 7) != 0);
      re = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 2) == 0);
      do_instr(v, re, we, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
               $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom);
    end

    @(posedge clk);
    #2;
    mon_en = 0;
    exp_vld = 0;
    chk("scoreboard_drained", q.size(), 0);

    // Reset in the middle of an access, then a stray late ack.
    @(negedge clk);
    valid_in = 1; mem_re_in = 1; mem_we_in = 0; alu_in = 32'h300; dmem_ack = 0;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pre_reset_req", dmem_req, 1);
    #2;
    reset = 0;
    #1;
    chk_outputs_zero("mid_reset");
    chk("mid_reset_stall", stall_out, 0);
    @(negedge clk);
    reset = 1;
    dmem_ack = 1; dmem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    chk("late_ack_valid", valid_out, 0);
    chk("late_ack_req", dmem_req, 0);
    @(negedge clk);
    dmem_ack = 0;

`ifdef MEM_TIMEOUT_EN
    // Load that never sees an ack must abort after TO_CYC access cycles.
    @(negedge clk);
    valid_in = 1; mem_re_in = 1; reg_file_write_in = 1; alu_in = 32'h440;
    for (int k = 0; k < TO_CYC; k++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk("to_req", dmem_req, 1);
      chk("to_stall", stall_out, 1);
      chk("to_err_early", err_out, 0);
    end
    @(negedge clk);
    #1;
    chk("to_req_dropped", dmem_req, 0);
    chk("to_err", err_out, 1);
    chk("to_valid", valid_out, 0);
    chk("to_rfw", reg_file_write_out, 0);
    chk("to_stall_clear", stall_out, 0);
    @(negedge clk);
    #1;
    chk("to_err_sticky", err_out, 1);
`else
    chk("err_tied_low", err_out, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles awaiting dmem_ack before abort (only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports: clk in 1, single clock; all state on rising edge.
REQ-003 reset in 1; asynchronous, active-low (0 = reset).
REQ-004 valid_in in 1, EX/MEM entry holds a real instruction; mem_re_in in 1, load; mem_we_in in 1, store; reg_file_write_in in 1; branch_in in 1, branch taken.
REQ-005 select_mux_2_in in 2, select_mux_4_in in 2, WB mux selects; reg_b_in in 32, store data; alu_in in 32, address/result; add_pc_in in 32, branch target.
REQ-006 dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_ack in 1; dmem_rdata in 32.
REQ-007 stall_out out 1, freeze upstream stages; pc_src_out out 1, redirect fetch; branch_target_out out 32.
REQ-008 MEM/WB outputs: valid_out 1, reg_file_write_out 1, select_mux_2_out 2, select_mux_4_out 2, mem_data_out 32, alu_out 32, add_pc_out 32; err_out 1.

Function
REQ-009 FSM states IDLE, ACCESS; reset state IDLE.
REQ-010 IDLE, valid_in=0: next edge loads bubble into MEM/WB (valid_out=0, reg_file_write_out=0).
REQ-011 IDLE, valid_in=1, no mem op: next edge loads MEM/WB with inputs, mem_data_out=0; latency 1; stall_out=0.
REQ-012 IDLE, valid_in=1 and (mem_re_in|mem_we_in): stall_out=1 combinationally, MEM/WB loads bubble, next edge -> ACCESS with op, address, wdata, and WB controls latched internally.
REQ-013 ACCESS: dmem_req=1, dmem_we=latched store, dmem_addr/dmem_wdata=latched values, all held stable until ack.
REQ-014 ACCESS, dmem_ack=0: stay; stall_out=1; MEM/WB loads bubble.
REQ-015 ACCESS, dmem_ack=1: stall_out=0 same cycle; next edge MEM/WB loads latched entry, mem_data_out=dmem_rdata for load else 0; -> IDLE; minimum mem-op latency 2 cycles.
REQ-016 mem_re_in and mem_we_in both 1: treated as store; mem_data_out=0.
REQ-017 dmem_req=0, dmem_we=0 in IDLE; dmem_addr/dmem_wdata=0 in IDLE.
REQ-018 pc_src_out = valid_in & branch_in & IDLE & no mem op, combinational; branch_target_out = add_pc_in when pc_src_out else 0.
REQ-019 stall_out = (IDLE & valid_in & (mem_re_in|mem_we_in)) | (ACCESS & ~dmem_ack).
REQ-020 Inputs ignored while in ACCESS (upstream frozen by stall_out).

Reset
REQ-021 reset=0 asynchronously: state IDLE, dmem_req=0, all outputs and latched fields 0, err_out=0, timeout counter 0.
REQ-022 Reset mid-ACCESS: transaction abandoned, dmem_req drops without waiting for ack; late ack after release ignored in IDLE.

Configuration
REQ-023 Macro MEM_TIMEOUT_EN defined: counter increments each ACCESS cycle without ack, cleared on IDLE entry; at count TIMEOUT_CYCLES-1 with no ack, next edge -> IDLE, MEM/WB bubble, err_out set sticky until reset.
REQ-024 MEM_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, err_out tied 0.

Structure
REQ-025 Package mem_stage_pkg SHALL hold state enum, WB-select width constant (2), data width (32), TIMEOUT_CYCLES default.
REQ-026 MEM/WB register SHALL be sub-module mem_wb_reg (async active-low reset, load-bubble input); FSM and dmem interface in mem_stage.

Verification
REQ-027 ALU op: valid_in=1, alu_in=0x0000_0055, reg_file_write_in=1 -> next edge alu_out=0x55, valid_out=1, stall_out=0 throughout.
REQ-028 Load, ack after 3 ACCESS cycles, dmem_rdata=0xDEAD_BEEF, alu_in=0x100 -> dmem_addr=0x100 stable, stall_out high 4 cycles, mem_data_out=0xDEAD_BEEF.
REQ-029 Store alu_in=0x40, reg_b_in=0x1234 with ack in first ACCESS cycle -> dmem_we=1, dmem_wdata=0x1234, valid_out=1 two edges after accept, mem_data_out=0.
REQ-030 Branch: branch_in=1, add_pc_in=0x80 -> pc_src_out=1, branch_target_out=0x80 same cycle; valid_in=0 -> pc_src_out=0.
REQ-031 reset=0 mid-ACCESS -> dmem_req=0 immediately, all outputs 0; ack after release produces no MEM/WB entry.
REQ-032 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack -> after 4 ACCESS cycles state IDLE, err_out=1, reg_file_write_out=0.
